addsub_share_arbiter: RTL and testbench
=======================================

// Module: addsub_share_arbiter
// PURPOSE
//  Shares one SB_MAC16-based 32-bit add/sub unit between NREQ requesters in the RV32I core.
//  Typical requesters: ALU, branch-target and load/store address paths.
//  Round-robin arbitration, registered operand issue and a pipelined result return
//  tagged back to the winning requester.
//  Sits between the requesters and the DSP add/sub wrapper. The DSP path is combinational.
// PARAMETERS
//  NREQ     2  number of requesters, legal 2..4
//  LATENCY  1  result-register stages after operand issue, legal 1..2
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  req_valid  in   NREQ     request i pending
//  req_sub    in   NREQ     1 = op_a - op_b, 0 = op_a + op_b
//  req_op_a   in   32*NREQ  operand A, requester i at [32*i+31:32*i]
//  req_op_b   in   32*NREQ  operand B, same packing
//  req_ready  out  NREQ     one-hot grant, combinational from valid and pointer
//  rsp_valid  out  NREQ     one-hot, result belongs to requester i
//  rsp_data   out  32       result, valid only while |rsp_valid
//  dsp_a      out  32       registered operand A to DSP wrapper
//  dsp_b      out  32       registered operand B to DSP wrapper
//  dsp_sub    out  1        registered subtract select to DSP wrapper
//  dsp_result in   32       combinational DSP result (dsp_a +/- dsp_b)
// BEHAVIOUR
//  Reset state
//   - rr pointer = 0; tag pipeline cleared.
//   - rsp_valid = 0, rsp_data = 0, dsp_a = dsp_b = 0, dsp_sub = 0.
//  Arbitration
//   - Search starts at pointer, ascending mod NREQ.
//   - The first i with req_valid[i] gets req_ready[i]. At most one bit set; 0 if no valid.
//   - Handshake = req_valid[i] & req_ready[i], at most one per cycle.
//   - After a handshake on i, pointer <= (i+1) mod NREQ. With no handshake the pointer holds.
//  Requester rules
//   - Requester holds valid, sub and operands stable until its handshake.
//   - Dropping valid before ready is legal; no issue occurs.
//  Issue
//   - At handshake edge E0: dsp_a, dsp_b, dsp_sub <= selected operands.
//   - A one-hot tag <= grant is captured at the same edge.
//   - With no handshake, dsp_* hold their value and the tag is zero (bubble).
//  Return
//   - At edge E0+LATENCY: rsp_data <= dsp_result (LATENCY=2 adds one register stage).
//   - rsp_valid <= delayed tag. rsp_valid is high for exactly one cycle per accepted request.
//   - Fully pipelined: one accept per cycle, results in order.
//   - No response back-pressure; the consumer must take the result the cycle it is valid.
//  Arithmetic: modulo 2^32, two's complement. No carry or overflow output.
//   - 0xFFFFFFFF + 1 = 0.
//   - 0 - 1 = 0xFFFFFFFF.
//  rsp_data holds its last value when rsp_valid = 0.
//  Reset mid-operation: every in-flight tag is discarded; no rsp_valid after reset.
//  Reset overrides a simultaneous handshake; req_ready is forced to 0 while reset = 1.
// CONFIGURATION
//  ADDSUB_ARB_LOCK_EN defined
//   - Adds port req_lock (in, NREQ).
//   - If req_lock[i] = 1 at a handshake on i, the pointer stays on i instead of advancing.
//   - i therefore wins the next cycle if still valid, for back-to-back multi-op sequences.
//   - Lock is released by a handshake with req_lock[i] = 0, or by dropping req_valid[i].
//   - If i is not valid while the pointer sits on it, normal search from i applies.
//  ADDSUB_ARB_LOCK_EN undefined
//   - No req_lock port; pure round-robin as above.
// TESTING
//  1 req0 add 5+7, NREQ=2, LATENCY=1
//    -> req_ready=01 same cycle; dsp_a=5, dsp_b=7 after E0; rsp_valid=01, rsp_data=12 after E1.
//  2 req1 sub 3-5
//    -> rsp_valid=10, rsp_data=0xFFFFFFFE; wrap: 0xFFFFFFFF+1 -> rsp_data=0.
//  3 req0 and req1 both valid for 4 cycles (operands 1+1, 2+2 ...)
//    -> grants 01,10,01,10; rsp tags and data follow the same order, one per cycle.
//  4 LATENCY=2, back-to-back accepts
//    -> each rsp_valid exactly 2 edges after its handshake; no gaps, no duplicates.
//  5 reset asserted the cycle after a handshake
//    -> rsp_valid stays 0; all outputs 0; pointer 0, so req1-only gets granted next.
//  6 ADDSUB_ARB_LOCK_EN: req0 locked for 3 ops while req1 waits
//    -> grants 01,01,01,10; without the macro: 01,10,01,10.

Source files
------------

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter
//   Shares one combinational 32-bit add/sub unit (DSP wrapper) between NREQ
//   requesters. The arbiter is round-robin. Operands are registered on issue,
//   and each result returns to the winner LATENCY edges after its handshake.
//
// Parameters
//   NREQ        number of requesters, 2..4
//   LATENCY     result-register stages after operand issue, 1..2
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req_valid   per-requester request pending
//   req_sub     per-requester op select: 1 = a - b, 0 = a + b
//   req_op_a    operand A, requester i at [32*i+31:32*i]
//   req_op_b    operand B, same packing
//   req_lock    (ADDSUB_ARB_LOCK_EN only) keep the pointer on i after its handshake
//   req_ready   one-hot grant, combinational from valid and pointer
//   rsp_valid   one-hot result owner, registered
//   rsp_data    result, holds its last value while rsp_valid is zero
//   dsp_a/b     registered operands to the DSP wrapper
//   dsp_sub     registered subtract select to the DSP wrapper
//   dsp_result  combinational DSP result (dsp_a +/- dsp_b)
//
// Optional feature macro: ADDSUB_ARB_LOCK_EN

module addsub_share_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [32*NREQ-1:0]   req_op_a,
  input  logic [32*NREQ-1:0]   req_op_b,
`ifdef ADDSUB_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [31:0]          dsp_a,
  output logic [31:0]          dsp_b,
  output logic                 dsp_sub,
  input  logic [31:0]          dsp_result
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] tag_q;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            sel_sub;
  logic            grant_found;

  // Round-robin search starting at the pointer; blocked entirely during reset.
  always_comb begin
    req_ready   = '0;
    grant_found = 1'b0;
    if (!reset) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!grant_found && (i == ((32'(ptr_q) + k) % NREQ)) && req_valid[i]) begin
            req_ready[i] = 1'b1;
            grant_found  = 1'b1;
          end
        end
      end
    end
  end

  // Pointer advances past the winner, or stays on it while it holds its lock.
  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        ptr_d = PW'((i + 1) % NREQ);
`ifdef ADDSUB_ARB_LOCK_EN
        if (req_lock[i]) ptr_d = PW'(i);
`endif
      end
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_a   = req_op_a[DW*i +: DW];
        sel_b   = req_op_b[DW*i +: DW];
        sel_sub = req_sub[i];
      end
    end
  end

  // Pointer, operand issue and first tag stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      tag_q   <= '0;
      dsp_a   <= '0;
      dsp_b   <= '0;
      dsp_sub <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= req_ready;
      if (|req_ready) begin
        dsp_a   <= sel_a;
        dsp_b   <= sel_b;
        dsp_sub <= sel_sub;
      end
    end
  end

  // Result return; data only updates when a tag arrives so it holds otherwise.
  if (LATENCY >= 2) begin : g_lat2
    logic [NREQ-1:0] tag2_q;
    logic [DW-1:0]   data2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        tag2_q    <= '0;
        data2_q   <= '0;
        rsp_valid <= '0;
        rsp_data  <= '0;
      end else begin
        tag2_q    <= tag_q;
        rsp_valid <= tag2_q;
        if (|tag_q)  data2_q  <= dsp_result;
        if (|tag2_q) rsp_data <= data2_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        rsp_valid <= '0;
        rsp_data  <= '0;
      end else begin
        rsp_valid <= tag_q;
        if (|tag_q) rsp_data <= dsp_result;
      end
    end
  end

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: two instances (LATENCY 1 and 2) share one
// stimulus stream. A cycle-indexed reference model predicts grants, issue
// registers and returned results from the arbitration and arithmetic rules.

module tb_addsub_share_arbiter;

  localparam int unsigned N    = 2;
  localparam int          MAXC = 1024;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_sub;
  logic [32*N-1:0] req_op_a;
  logic [32*N-1:0] req_op_b;
`ifdef ADDSUB_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif

  logic [N-1:0] ready1, ready2, rsp_valid1, rsp_valid2;
  logic [31:0]  rsp_data1, rsp_data2, dsp_a1, dsp_a2, dsp_b1, dsp_b2;
  logic         dsp_sub1, dsp_sub2;
  logic [31:0]  dsp_result1, dsp_result2;

  // Behavioural DSP wrappers.
  assign dsp_result1 = dsp_sub1 ? dsp_a1 - dsp_b1 : dsp_a1 + dsp_b1;
  assign dsp_result2 = dsp_sub2 ? dsp_a2 - dsp_b2 : dsp_a2 + dsp_b2;

  addsub_share_arbiter #(.NREQ(N), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sub(req_sub),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
`ifdef ADDSUB_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .dsp_a(dsp_a1), .dsp_b(dsp_b1), .dsp_sub(dsp_sub1), .dsp_result(dsp_result1)
  );

  addsub_share_arbiter #(.NREQ(N), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sub(req_sub),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
`ifdef ADDSUB_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(ready2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .dsp_a(dsp_a2), .dsp_b(dsp_b2), .dsp_sub(dsp_sub2), .dsp_result(dsp_result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state.
  int          ptr;
  int          cyc;
  logic [N-1:0] last_g;
  logic        hist_v [MAXC];
  logic [N-1:0] hist_g [MAXC];
  logic [31:0] hist_d [MAXC];
  logic [31:0] last_d [2];
  logic [31:0] exp_a, exp_b;
  logic        exp_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    req_op_a[32*i +: 32] = a;
    req_op_b[32*i +: 32] = b;
    req_sub[i]           = s;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: check the grant before the edge, then registered outputs after it.
  task automatic step();
    int           gi;
    int           c0;
    int           idx;
    logic [N-1:0] g;
    logic [N-1:0] ev;
    logic [31:0]  ed;
    logic [31:0]  a, b;
    logic         s;
    gi = -1;
    g  = '0;
    if (!reset) begin
      for (int k = 0; k < int'(N); k++) begin
        idx = (ptr + k) % int'(N);
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    last_g = g;
    #1;
    chk("ready_lat1", 32'(ready1), 32'(g));
    chk("ready_lat2", 32'(ready2), 32'(g));

    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      ptr   = 0;
      exp_a = '0;
      exp_b = '0;
      exp_s = 1'b0;
      hist_v[cyc] = 1'b0;
      if (cyc >= 1) hist_v[cyc-1] = 1'b0;
      if (cyc >= 2) hist_v[cyc-2] = 1'b0;
      last_d[0] = '0;
      last_d[1] = '0;
    end else if (gi >= 0) begin
      a = req_op_a[32*gi +: 32];
      b = req_op_b[32*gi +: 32];
      s = req_sub[gi];
      hist_v[cyc] = 1'b1;
      hist_g[cyc] = g;
      hist_d[cyc] = s ? a - b : a + b;
      exp_a = a;
      exp_b = b;
      exp_s = s;
      ptr = (gi + 1) % int'(N);
`ifdef ADDSUB_ARB_LOCK_EN
      if (req_lock[gi]) ptr = gi;
`endif
    end else begin
      hist_v[cyc] = 1'b0;
    end

    chk("dsp_a_lat1", dsp_a1, exp_a);
    chk("dsp_b_lat1", dsp_b1, exp_b);
    chk("dsp_sub_lat1", 32'(dsp_sub1), 32'(exp_s));
    chk("dsp_a_lat2", dsp_a2, exp_a);
    chk("dsp_b_lat2", dsp_b2, exp_b);
    chk("dsp_sub_lat2", 32'(dsp_sub2), 32'(exp_s));

    for (int d = 0; d < 2; d++) begin
      c0 = cyc - (d + 1);
      ev = '0;
      ed = last_d[d];
      if (!reset && c0 >= 0 && hist_v[c0]) begin
        ev = hist_g[c0];
        ed = hist_d[c0];
        last_d[d] = ed;
      end
      if (d == 0) begin
        chk("rsp_valid_lat1", 32'(rsp_valid1), 32'(ev));
        chk("rsp_data_lat1", rsp_data1, ed);
      end else begin
        chk("rsp_valid_lat2", 32'(rsp_valid2), 32'(ev));
        chk("rsp_data_lat2", rsp_data2, ed);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  initial begin
    logic [N-1:0] exp6 [4];
    int           n0;

    for (int i = 0; i < MAXC; i++) hist_v[i] = 1'b0;
    ptr = 0; cyc = 0; last_g = '0;
    last_d[0] = '0; last_d[1] = '0;
    exp_a = '0; exp_b = '0; exp_s = 1'b0;
    reset = 1'b1; req_valid = '0; req_sub = '0; req_op_a = '0; req_op_b = '0;
`ifdef ADDSUB_ARB_LOCK_EN
    req_lock = '0;
`endif

    // Reset state.
    step(); step();
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_rsp_data", rsp_data2, 32'd0);
    reset = 1'b0;
    step();

    // 1: req0 adds 5 + 7.
    set_op(0, 32'd5, 32'd7, 1'b0);
    req_valid = 2'b01;
    step();
    chk("t1_grant", 32'(last_g), 32'd1);
    chk("t1_dsp_a", dsp_a1, 32'd5);
    chk("t1_dsp_b", dsp_b1, 32'd7);
    idle(1);
    chk("t1_rsp_valid", 32'(rsp_valid1), 32'd1);
    chk("t1_rsp_data", rsp_data1, 32'd12);
    idle(2);

    // 2: req1 subtracts 3 - 5, then wraps 0xFFFFFFFF + 1.
    set_op(1, 32'd3, 32'd5, 1'b1);
    req_valid = 2'b10;
    step();
    set_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    chk("t2_sub_valid", 32'(rsp_valid1), 32'd2);
    chk("t2_sub_data", rsp_data1, 32'hFFFF_FFFE);
    idle(1);
    chk("t2_wrap_data", rsp_data1, 32'd0);
    chk("t2_wrap_data_lat2", rsp_data2, 32'hFFFF_FFFE);
    idle(2);
    chk("t2_hold_data", rsp_data1, 32'd0);

    // 3/4: both requesters valid for 4 cycles, back-to-back accepts.
    set_op(0, 32'd1, 32'd1, 1'b0);
    set_op(1, 32'd2, 32'd2, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_grant", 32'(last_g), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (last_g[0]) set_op(0, 32'(k + 3), 32'(k + 3), 1'b0);
      if (last_g[1]) set_op(1, 32'(k + 3), 32'(k + 3), 1'b0);
    end
    idle(1);
    chk("t3_last_rsp", rsp_data1, 32'd8);
    idle(2);

    // 5: reset the cycle after a handshake.
    set_op(0, 32'd9, 32'd9, 1'b0);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    chk("t5_rsp_valid_lat1", 32'(rsp_valid1), 32'd0);
    chk("t5_dsp_a", dsp_a1, 32'd0);
    reset = 1'b0;
    step();
    chk("t5_rsp_valid_lat2", 32'(rsp_valid2), 32'd0);
    set_op(1, 32'd4, 32'd1, 1'b1);
    req_valid = 2'b10;
    step();
    chk("t5_req1_grant", 32'(last_g), 32'd2);
    idle(3);

    // 6: req0 issues 3 ops while req1 keeps a request pending.
`ifdef ADDSUB_ARB_LOCK_EN
    exp6[0] = 2'b01; exp6[1] = 2'b01; exp6[2] = 2'b01; exp6[3] = 2'b10;
    req_lock = 2'b01;
`else
    exp6[0] = 2'b01; exp6[1] = 2'b10; exp6[2] = 2'b01; exp6[3] = 2'b10;
`endif
    n0 = 0;
    set_op(0, 32'd10, 32'd1, 1'b0);
    set_op(1, 32'd20, 32'd2, 1'b1);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_grant", 32'(last_g), 32'(exp6[k]));
      if (last_g[0]) begin
        n0++;
        if (n0 == 3) req_valid[0] = 1'b0;
        else set_op(0, 32'(10 + n0), 32'd1, 1'b0);
`ifdef ADDSUB_ARB_LOCK_EN
        req_lock[0] = (n0 < 2);
`endif
      end
      if (last_g[1]) set_op(1, 32'(30 + k), 32'd2, 1'b1);
    end
`ifdef ADDSUB_ARB_LOCK_EN
    req_lock = '0;
`endif
    idle(3);

    // Random traffic: requesters hold their operands until accepted or drop.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (last_g[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
`ifdef ADDSUB_ARB_LOCK_EN
          req_lock[i] = ($urandom_range(0, 2) == 0);
`endif
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
